// File: rtl/csi2_packet_parser_if.sv
// Lane-byte input and decoded packet output bundle of the CSI-2 packet parser.
// master = lane receiver / consumer side, slave = the parser.
interface csi2_packet_parser_if;
    logic       rx_hs_i;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       pix_valid_o;
    logic [7:0] pix_data_o;
    logic       pix_last_o;
    logic [5:0] pix_dt_o;
    logic       frame_active_o;
    logic       sof_o;
    logic       eof_o;
    logic       sol_o;
    logic       eol_o;
    logic       err_trunc_o;
    logic       err_ecc_o;

    modport master (
        output rx_hs_i, rx_valid_i, rx_data_i,
        input  pix_valid_o, pix_data_o, pix_last_o, pix_dt_o, frame_active_o,
        input  sof_o, eof_o, sol_o, eol_o, err_trunc_o, err_ecc_o
    );

    modport slave (
        input  rx_hs_i, rx_valid_i, rx_data_i,
        output pix_valid_o, pix_data_o, pix_last_o, pix_dt_o, frame_active_o,
        output sof_o, eof_o, sol_o, eol_o, err_trunc_o, err_ecc_o
    );
endinterface

// File: rtl/csi2_packet_parser.sv
// Single-lane CSI-2 packet layer: strips sync/header/CRC, decodes FS/FE/LS/LE, forwards payload.
// Optional header ECC check enabled by defining CSI2_ECC_CHECK_EN.
module csi2_packet_parser #(
    parameter logic [1:0]  VC     = 2'd0,
    parameter int unsigned WC_MAX = 4096,
    parameter logic [7:0]  SYNC   = 8'hB8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    csi2_packet_parser_if.slave  bus
);

    localparam int unsigned WC_W  = 16;
    localparam int unsigned HDR_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CRC,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [HDR_W-1:0]  hdr_q, hdr_d;
    logic [WC_W-1:0]   count_q, count_d;
    logic              pix_valid_q, pix_valid_d;
    logic [7:0]        pix_data_q, pix_data_d;
    logic              pix_last_q, pix_last_d;
    logic [5:0]        pix_dt_q, pix_dt_d;
    logic              frame_active_q, frame_active_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              sol_q, sol_d;
    logic              eol_q, eol_d;
    logic              err_trunc_q, err_trunc_d;
    logic              err_ecc_q, err_ecc_d;

    logic [7:0]        di_c;
    logic [WC_W-1:0]   wc_c;
    logic              ecc_ok_c;

    assign di_c = hdr_q[7:0];
    assign wc_c = hdr_q[23:8];

`ifdef CSI2_ECC_CHECK_EN
    // Each parity bit is the XOR of the header bits selected by its mask (D[23:0] = {WC, DI}).
    localparam logic [HDR_W-1:0] ECC_MASK [6] = '{
        24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00
    };

    function automatic logic [5:0] ecc_calc(input logic [HDR_W-1:0] d);
        logic [5:0] e;
        for (int i = 0; i < 6; i++) begin
            e[i] = ^(d & ECC_MASK[i]);
        end
        return e;
    endfunction

    assign ecc_ok_c = (ecc_calc(hdr_q) == bus.rx_data_i[5:0]);
`else
    assign ecc_ok_c = 1'b1;
`endif

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 2'd0;
            hdr_q          <= '0;
            count_q        <= '0;
            pix_valid_q    <= 1'b0;
            pix_data_q     <= 8'd0;
            pix_last_q     <= 1'b0;
            pix_dt_q       <= 6'd0;
            frame_active_q <= 1'b0;
            sof_q          <= 1'b0;
            eof_q          <= 1'b0;
            sol_q          <= 1'b0;
            eol_q          <= 1'b0;
            err_trunc_q    <= 1'b0;
            err_ecc_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hdr_q          <= hdr_d;
            count_q        <= count_d;
            pix_valid_q    <= pix_valid_d;
            pix_data_q     <= pix_data_d;
            pix_last_q     <= pix_last_d;
            pix_dt_q       <= pix_dt_d;
            frame_active_q <= frame_active_d;
            sof_q          <= sof_d;
            eof_q          <= eof_d;
            sol_q          <= sol_d;
            eol_q          <= eol_d;
            err_trunc_q    <= err_trunc_d;
            err_ecc_q      <= err_ecc_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hdr_d          = hdr_q;
        count_d        = count_q;
        pix_valid_d    = 1'b0;
        pix_data_d     = pix_data_q;
        pix_last_d     = 1'b0;
        pix_dt_d       = pix_dt_q;
        frame_active_d = frame_active_q;
        sof_d          = 1'b0;
        eof_d          = 1'b0;
        sol_d          = 1'b0;
        eol_d          = 1'b0;
        err_trunc_d    = 1'b0;
        err_ecc_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_hs_i && bus.rx_valid_i && (bus.rx_data_i == SYNC)) begin
                    state_d = ST_HDR;
                    cnt_d   = 2'd0;
                end
            end

            ST_HDR: begin
                if (!bus.rx_hs_i) begin
                    err_trunc_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (bus.rx_valid_i) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0:    hdr_d[7:0]   = bus.rx_data_i;
                        2'd1:    hdr_d[15:8]  = bus.rx_data_i;
                        2'd2:    hdr_d[23:16] = bus.rx_data_i;
                        default: begin
                            // ECC byte: the whole header is now known
                            state_d = ST_DRAIN;
                            cnt_d   = 2'd0;
                            if (!ecc_ok_c) begin
                                err_ecc_d = 1'b1;
                            end else if (di_c[7:6] != VC) begin
                                state_d = ST_DRAIN;
                            end else if (di_c[5:0] < 6'h10) begin
                                case (di_c[5:0])
                                    6'h00: begin
                                        sof_d          = 1'b1;
                                        frame_active_d = 1'b1;
                                    end
                                    6'h01: begin
                                        eof_d          = 1'b1;
                                        frame_active_d = 1'b0;
                                    end
                                    6'h02:   sol_d = 1'b1;
                                    6'h03:   eol_d = 1'b1;
                                    default: ;
                                endcase
                            end else if (32'(wc_c) <= WC_MAX) begin
                                pix_dt_d = di_c[5:0];
                                count_d  = wc_c;
                                state_d  = (wc_c == '0) ? ST_CRC : ST_PAYLOAD;
                            end
                        end
                    endcase
                end
            end

            ST_PAYLOAD: begin
                if (!bus.rx_hs_i) begin
                    err_trunc_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (bus.rx_valid_i) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = bus.rx_data_i;
                    if (count_q == WC_W'(1)) begin
                        pix_last_d = 1'b1;
                        state_d    = ST_CRC;
                        cnt_d      = 2'd0;
                    end
                    count_d = count_q - WC_W'(1);
                end
            end

            ST_CRC: begin
                if (!bus.rx_hs_i) begin
                    err_trunc_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (bus.rx_valid_i) begin
                    if (cnt_q == 2'd1) begin
                        state_d = ST_DRAIN;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            ST_DRAIN: begin
                if (!bus.rx_hs_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.pix_valid_o    = pix_valid_q;
    assign bus.pix_data_o     = pix_data_q;
    assign bus.pix_last_o     = pix_last_q;
    assign bus.pix_dt_o       = pix_dt_q;
    assign bus.frame_active_o = frame_active_q;
    assign bus.sof_o          = sof_q;
    assign bus.eof_o          = eof_q;
    assign bus.sol_o          = sol_q;
    assign bus.eol_o          = eol_q;
    assign bus.err_trunc_o    = err_trunc_q;
    assign bus.err_ecc_o      = err_ecc_q;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Bench for csi2_packet_parser: packet table plus truncation and reset sequences,
// payload bytes checked against a scoreboard queue (data, last flag, latency).
module tb_csi2_packet_parser;

    localparam logic [7:0] SYNC = 8'hB8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    csi2_packet_parser_if bus ();

    csi2_packet_parser dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } pix_exp_t;

    typedef struct {
        logic [7:0]  di;
        logic [15:0] wc;
        logic [7:0]  ecc;
        int          n_send;
        bit          acc;
        logic [39:0] ev;   // expected pulse counts {sof, eof, sol, eol, ecc}
        bit          fa;
        logic [5:0]  dt;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    pix_exp_t sb[$];
    pix_exp_t mon_e;
    int n_sof = 0, n_eof = 0, n_sol = 0, n_eol = 0, n_ecc = 0, n_trunc = 0;
    int n_pix = 0, pix_bad = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Output monitor: counts pulses and checks payload bytes against the scoreboard
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (bus.sof_o)       n_sof++;
            if (bus.eof_o)       n_eof++;
            if (bus.sol_o)       n_sol++;
            if (bus.eol_o)       n_eol++;
            if (bus.err_ecc_o)   n_ecc++;
            if (bus.err_trunc_o) n_trunc++;
            if (bus.pix_valid_o) begin
                n_pix++;
                if (sb.size() == 0) begin
                    pix_bad++;
                    $display("  unexpected pix byte %02h last=%b cycle %0d",
                             bus.pix_data_o, bus.pix_last_o, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.pix_data_o !== mon_e.data || bus.pix_last_o !== mon_e.last ||
                        cyc != mon_e.cyc) begin
                        pix_bad++;
                        $display("  pix byte %02h last=%b cycle %0d, wanted %02h last=%b cycle %0d",
                                 bus.pix_data_o, bus.pix_last_o, cyc,
                                 mon_e.data, mon_e.last, mon_e.cyc);
                    end
                end
            end else if (bus.pix_last_o) begin
                pix_bad++;
                $display("  pix_last without pix_valid at cycle %0d", cyc);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic v, input logic [7:0] d);
        @(posedge clk_i);
        #1;
        bus.rx_hs_i    = hs;
        bus.rx_valid_i = v;
        bus.rx_data_i  = d;
    endtask

    // One valid byte, occasionally preceded by a stall cycle carrying junk data
    task automatic send_byte(input logic [7:0] d);
        if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b0, 8'($urandom));
        drive(1'b1, 1'b1, d);
    endtask

    task automatic hs_off(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, SYNC);
        send_byte(di);
        send_byte(wc[7:0]);
        send_byte(wc[15:8]);
        send_byte(ecc);
    endtask

    task automatic send_pay(input int n, input int n_wc, input bit acc);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'(i * 17 + 17);
            send_byte(d);
            if (acc) sb.push_back('{d, (i == n_wc - 1), cyc + 1});
        end
    endtask

    task automatic send_packet(input vec_t v);
        send_hdr(v.di, v.wc, v.ecc);
        send_pay(v.n_send, int'(v.wc), v.acc);
        send_byte(8'hC0);
        send_byte(8'hC1);
        hs_off(3);
    endtask

    function automatic logic [39:0] ev_snap();
        return {8'(n_sof), 8'(n_eof), 8'(n_sol), 8'(n_eol), 8'(n_ecc)};
    endfunction

    function automatic logic [22:0] out_snap();
        return {bus.pix_valid_o, bus.pix_data_o, bus.pix_last_o, bus.pix_dt_o,
                bus.frame_active_o, bus.sof_o, bus.eof_o, bus.sol_o, bus.eol_o,
                bus.err_trunc_o, bus.err_ecc_o};
    endfunction

    vec_t        vecs[15];
    vec_t        v;
    logic [39:0] ev0;
    int          pix0, bad0, tr0;

    initial begin
        // Table: {di, wc, ecc, n_send, acc, ev{sof,eof,sol,eol,ecc}, fa, dt}
        vecs[0]  = '{8'h00, 16'h0000, 8'h00, 0,    1'b0, 40'h01_00_00_00_00, 1'b1, 6'h00}; // FS
        vecs[1]  = '{8'h00, 16'h0000, 8'h00, 0,    1'b0, 40'h01_00_00_00_00, 1'b1, 6'h00}; // FS again
`ifdef CSI2_ECC_CHECK_EN
        vecs[2]  = '{8'h00, 16'h0001, 8'h00, 0,    1'b0, 40'h00_00_00_00_01, 1'b1, 6'h00}; // bad ECC
`else
        vecs[2]  = '{8'h00, 16'h0001, 8'h00, 0,    1'b0, 40'h01_00_00_00_00, 1'b1, 6'h00}; // ECC ignored
`endif
        vecs[3]  = '{8'h02, 16'h0000, 8'h0B, 0,    1'b0, 40'h00_00_01_00_00, 1'b1, 6'h00}; // LS
        vecs[4]  = '{8'h2A, 16'h0004, 8'h33, 4,    1'b1, 40'h00_00_00_00_00, 1'b1, 6'h2A}; // RAW8
        vecs[5]  = '{8'h03, 16'h0000, 8'h0C, 0,    1'b0, 40'h00_00_00_01_00, 1'b1, 6'h2A}; // LE
        vecs[6]  = '{8'h6A, 16'h0004, 8'h25, 4,    1'b0, 40'h00_00_00_00_00, 1'b1, 6'h2A}; // VC1
        vecs[7]  = '{8'h2A, 16'h2000, 8'h3F, 8,    1'b0, 40'h00_00_00_00_00, 1'b1, 6'h2A}; // WC too big
        vecs[8]  = '{8'h2A, 16'h1001, 8'h15, 8,    1'b0, 40'h00_00_00_00_00, 1'b1, 6'h2A}; // WC_MAX+1
        vecs[9]  = '{8'h1E, 16'h0001, 8'h01, 1,    1'b1, 40'h00_00_00_00_00, 1'b1, 6'h1E}; // WC=1
        vecs[10] = '{8'h2A, 16'h0000, 8'h10, 0,    1'b1, 40'h00_00_00_00_00, 1'b1, 6'h2A}; // WC=0
        vecs[11] = '{8'h2A, 16'h1000, 8'h0F, 4096, 1'b1, 40'h00_00_00_00_00, 1'b1, 6'h2A}; // WC_MAX
        vecs[12] = '{8'h08, 16'h0000, 8'h0E, 0,    1'b0, 40'h00_00_00_00_00, 1'b1, 6'h2A}; // generic short
        vecs[13] = '{8'h01, 16'h0000, 8'h07, 0,    1'b0, 40'h00_01_00_00_00, 1'b0, 6'h2A}; // FE
        vecs[14] = '{8'h01, 16'h0000, 8'h07, 0,    1'b0, 40'h00_01_00_00_00, 1'b0, 6'h2A}; // FE inactive

        bus.rx_hs_i    = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        #2 rst_i = 1'b1;
        #1 check("reset_outputs", 64'(out_snap()), 64'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        hs_off(2);

        for (int i = 0; i < 15; i++) begin
            v    = vecs[i];
            ev0  = ev_snap();
            pix0 = n_pix;
            bad0 = pix_bad;
            send_packet(v);
            check($sformatf("v%0d_events", i), 64'(ev_snap() - ev0), 64'(v.ev));
            check($sformatf("v%0d_frame_active", i), 64'(bus.frame_active_o), 64'(v.fa));
            check($sformatf("v%0d_pix_dt", i), 64'(bus.pix_dt_o), 64'(v.dt));
            check($sformatf("v%0d_pix_count", i), 64'(n_pix - pix0), 64'(v.acc ? v.n_send : 0));
            check($sformatf("v%0d_pix_bytes_bad", i), 64'(pix_bad - bad0), 64'd0);
            check($sformatf("v%0d_sb_left", i), 64'(sb.size()), 64'd0);
        end
        check("no_trunc_so_far", 64'(n_trunc), 64'd0);

        // Truncation: HS falls after 2 of 4 payload bytes
        tr0  = n_trunc;
        pix0 = n_pix;
        bad0 = pix_bad;
        send_hdr(8'h2A, 16'h0004, 8'h33);
        send_pay(2, 4, 1'b1);
        for (int i = 0; i < 2; i++) sb[sb.size() - 1 - i].last = 1'b0;
        hs_off(3);
        check("trunc_pulse", 64'(n_trunc - tr0), 64'd1);
        check("trunc_pix_count", 64'(n_pix - pix0), 64'd2);
        check("trunc_pix_bytes_bad", 64'(pix_bad - bad0), 64'd0);
        ev0 = ev_snap();
        send_packet('{8'h02, 16'h0000, 8'h0B, 0, 1'b0, 40'h0, 1'b0, 6'h0});
        check("after_trunc_ls", 64'(ev_snap() - ev0), 64'h00_00_01_00_00);

        // Reset asserted asynchronously mid-payload
        send_packet(vecs[0]);
        check("pre_reset_frame_active", 64'(bus.frame_active_o), 64'd1);
        send_hdr(8'h2A, 16'h0004, 8'h33);
        send_pay(2, 4, 1'b1);
        sb[sb.size() - 1].last = 1'b0;
        drive(1'b1, 1'b0, 8'h00);
        #6;
        check("pre_reset_pix_valid", 64'(bus.pix_valid_o), 64'd1);
        rst_i = 1'b1;
        #1 check("reset_mid_payload_outputs", 64'(out_snap()), 64'd0);
        tr0  = n_trunc;
        pix0 = n_pix;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        rst_i = 1'b0;
        drive(1'b1, 1'b1, 8'h33);
        drive(1'b1, 1'b1, 8'h44);
        drive(1'b1, 1'b1, 8'hC0);
        drive(1'b1, 1'b1, 8'hC1);
        hs_off(3);
        check("post_reset_no_pix", 64'(n_pix - pix0), 64'd0);
        check("post_reset_no_trunc", 64'(n_trunc - tr0), 64'd0);
        check("post_reset_sb_left", 64'(sb.size()), 64'd0);
        check("post_reset_frame_active", 64'(bus.frame_active_o), 64'd0);
        pix0 = n_pix;
        bad0 = pix_bad;
        send_packet(vecs[4]);
        check("post_reset_raw8_count", 64'(n_pix - pix0), 64'd4);
        check("post_reset_raw8_bad", 64'(pix_bad - bad0), 64'd0);
        check("post_reset_pix_dt", 64'(bus.pix_dt_o), 64'h2A);
`ifndef CSI2_ECC_CHECK_EN
        check("ecc_err_never", 64'(n_ecc), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
